program_loader: RTL and testbench

Sequences the control block's programming mode to stream a program image into RAM, one byte per instruction cycle. Accepts bytes from an external valid/ready source into a small FIFO. Aligns `programming` to instruction-cycle boundaries using the control block's `ready` (T0) pulse. Presents each byte on the input bus during T3 and retires it on `done_load` (T4). Sits between the pin-level byte source and control_block/top-level bus mux.

---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_fifo.sv | 56 +++++
 rtl/program_loader.sv | 152 +++++++++++++++
 tb/tb_program_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the program loader.
// Contents: loader FSM state encoding, FIFO pointer-width helper.
// Optional feature macro used by program_loader: LOADER_CHECKSUM_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    ALIGN  = 3'd2,
    LOAD   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: synchronous DEPTH x DATA_W byte FIFO with simultaneous push+pop.
// Latency: a pushed byte is visible on head the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, resetn (async, active-low flush), push/push_dat, pop,
//        head (FIFO head, undefined content when empty), full, empty.
module byte_fifo
  import loader_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int            AW       = fifo_ptr_w(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: head is only meaningful while level is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Purpose: streams NUM_BYTES program bytes into RAM through the control block's programming mode.
// Latency: programming rises on the first cpu_ready after the FIFO fills; one byte retired per done_load.
// Backpressure: byte_ready low when FIFO full, all bytes accepted, idle, or on an underrun cycle.
// Ports: clk, resetn (async active-low); start; byte_in/byte_valid/byte_ready source handshake;
//        cpu_ready (T0), read_ui_in (T3), done_load (T4) from the control block;
//        programming, load_data, busy, load_complete, underrun, checksum outputs.
// Optional feature: define LOADER_CHECKSUM_EN for a running sum of committed bytes on checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              cpu_ready,
  input  logic              read_ui_in,
  input  logic              done_load,
  output logic              programming,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              load_complete,
  output logic              underrun,
  output logic [DATA_W-1:0] checksum
);
  localparam int            CW      = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0] LAST    = CW'(NUM_BYTES);
  localparam logic [CW-1:0] LAST_M1 = CW'(NUM_BYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     rx_cnt;
  logic [CW-1:0]     wr_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              push;
  logic              pop;
  logic              load_start;
  logic              prog_set;
  logic              underrun_evt;
  logic              done_evt;
  logic              wr_last;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_dat (byte_in),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   if (fifo_full || rx_cnt == LAST) state_nxt = ALIGN;
      ALIGN:   if (cpu_ready) state_nxt = LOAD;
      LOAD: begin
        if (underrun_evt) state_nxt = IDLE;
        else if (wr_last) state_nxt = FINISH;
      end
      FINISH:  if (cpu_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes. An underrun fires when the CPU reaches T0 or T3 with
  // nothing to present; pop and underrun are exclusive since pop needs data.
  always_comb begin
    load_start   = 1'b0;
    prog_set     = 1'b0;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    done_evt     = 1'b0;
    case (state)
      IDLE:  load_start = start;
      ALIGN: prog_set   = cpu_ready;
      LOAD: begin
        pop          = done_load && !fifo_empty;
        underrun_evt = fifo_empty && ((cpu_ready && (wr_cnt < LAST)) || read_ui_in);
      end
      FINISH:  done_evt = cpu_ready;
      default: ;
    endcase
  end

  assign busy       = (state != IDLE);
  // Gating on underrun_evt drops any byte offered on the abort cycle.
  assign byte_ready = busy && !fifo_full && (rx_cnt < LAST) && !underrun_evt;
  assign push       = byte_valid && byte_ready;
  assign wr_last    = pop && (wr_cnt == LAST_M1);
  assign load_data  = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt        <= '0;
      wr_cnt        <= '0;
      underrun      <= 1'b0;
      programming   <= 1'b0;
      load_complete <= 1'b0;
    end else begin
      load_complete <= done_evt;
      if (load_start) begin
        rx_cnt   <= '0;
        wr_cnt   <= '0;
        underrun <= 1'b0;
      end else begin
        if (push)         rx_cnt   <= rx_cnt + 1'b1;
        if (pop)          wr_cnt   <= wr_cnt + 1'b1;
        if (underrun_evt) underrun <= 1'b1;
      end
      // Set and clear events all coincide with a CPU strobe edge, so the
      // control block only ever sees programming change on cycle boundaries.
      if (prog_set)                      programming <= 1'b1;
      else if (underrun_evt || done_evt) programming <= 1'b0;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         sum_q <= '0;
    else if (load_start) sum_q <= '0;
    else if (pop)        sum_q <= sum_q + fifo_head;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int N = 16;
  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_ready;
  logic         cpu_ready = 1'b0;
  logic         read_ui_in = 1'b0;
  logic         done_load = 1'b0;
  logic         programming;
  logic [W-1:0] load_data;
  logic         busy;
  logic         load_complete;
  logic         underrun;
  logic [W-1:0] checksum;

  program_loader #(.NUM_BYTES(N), .DEPTH(D), .DATA_W(W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .cpu_ready     (cpu_ready),
    .read_ui_in    (read_ui_in),
    .done_load     (done_load),
    .programming   (programming),
    .load_data     (load_data),
    .busy          (busy),
    .load_complete (load_complete),
    .underrun      (underrun),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes accepted but not yet written, plus load progress.
  logic [W-1:0] mq[$];
  logic [W-1:0] src[$];
  logic [W-1:0] ram[N];
  logic [W-1:0] sum_m;
  int  accepted, committed, pc, stg;
  bit  active, prog_m, ur_m, lc_m, aligned;
  int  ld_bad, br_bad, prog_bad, st_bad, lc_cnt, max_lvl, end_kind;
  int  src_idx, p_valid, stall_after, stall_len, stall_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    active = 0; prog_m = 0; ur_m = 0; lc_m = 0; aligned = 0;
    accepted = 0; committed = 0; sum_m = '0;
  endtask

  // One clock: drive inputs at posedge+1, check outputs at posedge+2, advance model after the edge.
  task automatic iter(input bit start_req);
    bit start_evt, ur_evt, pop_evt, fin_evt, rise_evt, fill_now, push, exp_br;
    logic [W-1:0] head;
    start      = start_req;
    cpu_ready  = (stg == 0);
    read_ui_in = (stg == 3);
    done_load  = (stg == 4);
    byte_valid = 1'b0;
    byte_in    = W'($urandom);
    if (src_idx < src.size()) begin
      if (src_idx == stall_after && stall_cnt < stall_len) stall_cnt++;
      else if (int'($urandom_range(99)) < p_valid) begin
        byte_valid = 1'b1;
        byte_in    = src[src_idx];
      end
    end
    #1;
    head      = (mq.size() > 0) ? mq[0] : '0;
    ur_evt    = prog_m && mq.size() == 0 && committed < N && (cpu_ready || read_ui_in);
    pop_evt   = prog_m && done_load && mq.size() > 0;
    fin_evt   = prog_m && committed == N && cpu_ready;
    rise_evt  = active && aligned && !prog_m && cpu_ready;
    start_evt = !active && start;
    fill_now  = active && !aligned && (mq.size() == D || accepted == N);
    exp_br    = active && mq.size() < D && accepted < N && !ur_evt;
    if (load_data !== head) ld_bad++;
    if (byte_ready !== exp_br) br_bad++;
    if (programming !== prog_m) prog_bad++;
    if (busy !== active || underrun !== ur_m || load_complete !== lc_m) st_bad++;
`ifdef LOADER_CHECKSUM_EN
    if (checksum !== sum_m) st_bad++;
`else
    if (checksum !== '0) st_bad++;
`endif
    if (load_complete === 1'b1) lc_cnt++;
    push = byte_valid && byte_ready;
    if (prog_m && read_ui_in) ram[pc] = load_data;
    @(posedge clk);
    #1;
    stg  = (stg + 1) % 7;
    lc_m = 0;
    if (start_evt) begin
      active = 1; accepted = 0; committed = 0; ur_m = 0; aligned = 0; sum_m = '0; pc = 0;
    end
    if (push) begin
      mq.push_back(byte_in);
      accepted++;
      src_idx++;
    end
    if (pop_evt) begin
      sum_m = sum_m + mq.pop_front();
      committed++;
      pc = (pc + 1) % N;
    end
    if (fill_now) aligned = 1;
    if (rise_evt) prog_m = 1;
    if (ur_evt) begin ur_m = 1; prog_m = 0; active = 0; end_kind = 2; end
    if (fin_evt) begin prog_m = 0; active = 0; lc_m = 1; end_kind = 1; end
    if (mq.size() > max_lvl) max_lvl = mq.size();
  endtask

  task automatic reset_mid(input string tag);
    #3 resetn = 1'b0;
    #1;
    chk({tag, "_async_prog"}, 32'(programming), 32'd0);
    chk({tag, "_async_busy"}, 32'(busy), 32'd0);
    chk({tag, "_async_brdy"}, 32'(byte_ready), 32'd0);
    chk({tag, "_async_ldat"}, 32'(load_data), 32'd0);
    model_reset();
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    stg = (stg + 2) % 7;
  endtask

  // exp_end: 1 finish, 2 underrun, 3 reset, -1 whichever the model predicts.
  task automatic run_load(input string tag, input int p, input int s_after, input int s_len,
                          input bit start_mid, input int rst_at, input int exp_end);
    int n;
    int ram_bad;
    p_valid = p; stall_after = s_after; stall_len = s_len; stall_cnt = 0; src_idx = 0;
    ld_bad = 0; br_bad = 0; prog_bad = 0; st_bad = 0; lc_cnt = 0; max_lvl = 0; end_kind = 0;
    for (int i = 0; i < N; i++) ram[i] = '0;
    repeat ($urandom_range(3)) iter(1'b0);
    iter(1'b1);
    n = 0;
    while (end_kind == 0 && n < 3000) begin
      iter(start_mid && prog_m && committed == 3);
      if (rst_at >= 0 && end_kind == 0 && prog_m && committed == rst_at) begin
        reset_mid(tag);
        end_kind = 3;
      end
      n++;
    end
    iter(1'b0);
    iter(1'b0);
    chk({tag, "_ended"}, 32'(end_kind != 0), 32'd1);
    chk({tag, "_load_data"}, ld_bad, 0);
    chk({tag, "_byte_ready"}, br_bad, 0);
    chk({tag, "_programming"}, prog_bad, 0);
    chk({tag, "_status"}, st_bad, 0);
    if (exp_end >= 0) chk({tag, "_outcome"}, end_kind, exp_end);
    if (end_kind == 1) begin
      ram_bad = 0;
      for (int i = 0; i < N; i++) if (ram[i] !== src[i]) ram_bad++;
      chk({tag, "_lc_pulses"}, lc_cnt, 1);
      chk({tag, "_accepted"}, accepted, N);
      chk({tag, "_ram"}, ram_bad, 0);
    end else if (end_kind == 2) begin
      chk({tag, "_lc_pulses"}, lc_cnt, 0);
    end
  endtask

  task automatic fill_rand();
    src.delete();
    for (int i = 0; i < N; i++) src.push_back(W'($urandom));
  endtask

  initial begin
    logic [W-1:0] exp_sum;
    model_reset();
    pc = 0; stg = 0;
    #12;
    chk("reset_prog", 32'(programming), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_brdy", 32'(byte_ready), 32'd0);
    chk("reset_ldat", 32'(load_data), 32'd0);
    chk("reset_lc", 32'(load_complete), 32'd0);
    chk("reset_ur", 32'(underrun), 32'd0);
    chk("reset_cks", 32'(checksum), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fast source, bytes 0x10..0x1F, valid held high throughout.
    src.delete();
    for (int i = 0; i < N; i++) src.push_back(W'(8'h10 + i));
    run_load("fast", 100, -1, 0, 1'b0, -1, 1);
    chk("fast_max_level", max_lvl, D);

    // Source stalls after byte 5 long enough to drain the FIFO.
    fill_rand();
    run_load("stall", 100, 5, 40, 1'b0, -1, 2);
    chk("stall_ur_sticky", 32'(underrun), 32'd1);
    chk("stall_idle", 32'(busy), 32'd0);

    // A new start clears underrun and loads cleanly; start pulsed mid-load is ignored.
    fill_rand();
    run_load("start_mid", 100, -1, 0, 1'b1, -1, 1);

    // Reset after 7 committed bytes, then a clean load.
    fill_rand();
    run_load("rst_mid", 100, -1, 0, 1'b0, 7, 3);
    fill_rand();
    run_load("after_rst", 100, -1, 0, 1'b0, -1, 1);

    // Checksum pattern: 0x80, 0x90, then fourteen 0x01.
    src.delete();
    src.push_back(8'h80);
    src.push_back(8'h90);
    for (int i = 2; i < N; i++) src.push_back(8'h01);
    run_load("cks", 100, -1, 0, 1'b0, -1, 1);
    exp_sum = '0;
    for (int i = 0; i < N; i++) exp_sum = exp_sum + src[i];
`ifdef LOADER_CHECKSUM_EN
    chk("cks_value", 32'(checksum), 32'(exp_sum));
`else
    chk("cks_value", 32'(checksum), 32'd0);
`endif

    // Randomized source rates and stalls; the model decides finish vs underrun.
    for (int r = 0; r < 4; r++) begin
      int rates[4];
      rates = '{100, 70, 40, 15};
      fill_rand();
      run_load($sformatf("rand%0d", r), rates[r], int'($urandom_range(N - 1)),
               int'($urandom_range(20)), 1'b0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
